// File: rtl/loopback_fifo_pkg.sv
// Shared types and default parameter values for the loopback byte buffer.
package loopback_fifo_pkg;

  localparam int unsigned DATA_W             = 8;
  localparam int unsigned DEF_DEPTH_LOG2     = 4;
  localparam int unsigned DEF_LED_CYCLES     = 2400000;

  typedef logic [DATA_W-1:0] byte_t;

  // Width of a down-counter that must hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/loopback_fifo_if.sv
// Valid/ready byte streams between usb_cdc (OUT producer, IN consumer) and the buffer.
interface loopback_fifo_if;
  import loopback_fifo_pkg::*;

  byte_t out_data_i;
  logic  out_valid_i;
  logic  out_ready_o;
  byte_t in_data_o;
  logic  in_valid_o;
  logic  in_ready_i;

  modport fifo (
    input  out_data_i,
    input  out_valid_i,
    output out_ready_o,
    output in_data_o,
    output in_valid_o,
    input  in_ready_i
  );

  modport cdc (
    output out_data_i,
    output out_valid_i,
    input  out_ready_o,
    input  in_data_o,
    input  in_valid_o,
    output in_ready_i
  );

endinterface

// File: rtl/loopback_fifo_pulse_stretch.sv
// Retriggerable pulse stretcher: output stays high CYCLES clocks after the last trigger.
module pulse_stretch
  import loopback_fifo_pkg::*;
#(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic out_o
);

  localparam int unsigned CNT_W = cnt_width(CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (trig_i) begin
      w_cnt_nxt = CNT_W'(CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign out_o = (r_cnt != '0);

endmodule

// File: rtl/loopback_fifo.sv
// Loopback byte FIFO between usb_cdc OUT and IN streams, with RX/TX activity LEDs.
module loopback_fifo
  import loopback_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned LED_CYCLES = DEF_LED_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  loopback_fifo_if.fifo         bus,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  rx_led_o,
  output logic                  tx_led_o
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  byte_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [LVL_W-1:0] w_level_nxt;

  // Flags come only from the registered level so usb_cdc sees no comb path.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_wr_en = bus.out_valid_i & ~w_full;
  assign w_rd_en = bus.in_ready_i  & ~w_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_nxt;
    end
  end

  // Storage is left unreset so it can map onto LUT RAM / EBR.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.out_data_i;
    end
  end

  assign bus.out_ready_o = ~w_full;
  assign bus.in_valid_o  = ~w_empty;
  assign bus.in_data_o   = r_mem[r_rd_ptr];
  assign level_o         = r_level;

  pulse_stretch #(.CYCLES(LED_CYCLES)) u_rx_led (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .trig_i (w_wr_en),
    .out_o  (rx_led_o)
  );

  pulse_stretch #(.CYCLES(LED_CYCLES)) u_tx_led (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .trig_i (w_rd_en),
    .out_o  (tx_led_o)
  );

endmodule

// File: tb/tb_loopback_fifo.sv
// Self-checking bench for loopback_fifo: queue-based model plus directed literal checks.
module tb_loopback_fifo;
  import loopback_fifo_pkg::*;

  localparam int unsigned DL2  = 4;
  localparam int unsigned DEP  = 16;
  localparam int unsigned LEDC = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [DL2:0] level_o;
  logic       rx_led_o;
  logic       tx_led_o;

  loopback_fifo_if u_if ();

  loopback_fifo #(.DEPTH_LOG2(DL2), .LED_CYCLES(LEDC)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus      (u_if.fifo),
    .level_o  (level_o),
    .rx_led_o (rx_led_o),
    .tx_led_o (tx_led_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: byte queue and cycle stamps of the last RX/TX transfers.
  byte_t q[$];
  int    cyc     = 0;
  int    rx_last = -1000;
  int    tx_last = -1000;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q.delete();
      rx_last = -1000;
      tx_last = -1000;
    end else begin
      bit wr, rd;
      byte_t d;
      cyc++;
      wr = (u_if.out_valid_i === 1'b1) && (q.size() < DEP);
      rd = (u_if.in_ready_i === 1'b1) && (q.size() > 0);
      d  = u_if.out_data_i;
      if (rd) begin
        void'(q.pop_front());
        tx_last = cyc;
      end
      if (wr) begin
        q.push_back(d);
        rx_last = cyc;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("out_ready", int'(u_if.out_ready_o), int'(q.size() != DEP));
      chk("in_valid",  int'(u_if.in_valid_o),  int'(q.size() != 0));
      chk("level",     int'(level_o),          q.size());
      chk("rx_led",    int'(rx_led_o),         int'((cyc - rx_last) < LEDC));
      chk("tx_led",    int'(tx_led_o),         int'((cyc - tx_last) < LEDC));
      if (q.size() != 0) chk("in_data", int'(u_if.in_data_o), int'(q[0]));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic async_reset_check();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_out_ready", int'(u_if.out_ready_o), 1);
    chk("rst_in_valid",  int'(u_if.in_valid_o),  0);
    chk("rst_level",     int'(level_o),          0);
    chk("rst_rx_led",    int'(rx_led_o),         0);
    chk("rst_tx_led",    int'(tx_led_o),         0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int acc, wcnt, budget, hi;
    byte_t b;
    u_if.out_data_i  = '0;
    u_if.out_valid_i = 1'b0;
    u_if.in_ready_i  = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk_en = 1'b1;
    tick();

    // Mid-cycle asynchronous reset while the FIFO holds data and LEDs are on.
    u_if.out_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.out_data_i = byte_t'(8'hA0 + i);
      tick();
    end
    u_if.out_valid_i = 1'b0;
    async_reset_check();
    tick();

    // Seven writes with IN stalled, then drain.
    for (int i = 1; i <= 7; i++) begin
      u_if.out_valid_i = 1'b1;
      u_if.out_data_i  = byte_t'(i);
      tick();
    end
    u_if.out_valid_i = 1'b0;
    chk("seven_level", int'(level_o), 7);
    chk("seven_head",  int'(u_if.in_data_o), 8'h01);
    u_if.in_ready_i = 1'b1;
    repeat (8) tick();
    u_if.in_ready_i = 1'b0;
    chk("seven_drained", int'(level_o), 0);

    // Fill to full with valid held; the 17th byte must wait.
    b = 8'h41;
    u_if.out_valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      u_if.out_data_i = b;
      acc = int'(u_if.out_ready_o);
      tick();
      if (acc != 0) b = byte_t'(b + 8'd1);
    end
    chk("full_ready", int'(u_if.out_ready_o), 0);
    chk("full_level", int'(level_o), 16);
    chk("full_held",  int'(b), 8'h51);
    chk("full_head",  int'(u_if.in_data_o), 8'h41);
    u_if.in_ready_i = 1'b1;
    tick();
    u_if.in_ready_i = 1'b0;
    chk("after_pop_level", int'(level_o), 15);
    tick();
    chk("refill_level", int'(level_o), 16);
    chk("refill_head",  int'(u_if.in_data_o), 8'h42);
    u_if.out_valid_i = 1'b0;
    u_if.in_ready_i  = 1'b1;
    repeat (17) tick();
    u_if.in_ready_i = 1'b0;
    chk("fill_drained", int'(level_o), 0);

    // Continuous streaming 0x00..0xFF.
    wcnt = 0;
    budget = 0;
    u_if.out_data_i  = 8'h00;
    u_if.out_valid_i = 1'b1;
    u_if.in_ready_i  = 1'b1;
    while (wcnt < 256 && budget < 600) begin
      acc = int'(u_if.out_ready_o);
      tick();
      budget++;
      if (acc != 0) begin
        wcnt++;
        u_if.out_data_i = byte_t'(wcnt);
      end
      chk("stream_level", int'(level_o), 1);
    end
    if (wcnt < 256) chk("stream_timeout", wcnt, 256);
    u_if.out_valid_i = 1'b0;
    tick();
    u_if.in_ready_i = 1'b0;
    chk("stream_drained", int'(level_o), 0);

    // Random valid/ready on both sides, 1000 accepted bytes.
    wcnt = 0;
    budget = 0;
    while (wcnt < 1000 && budget < 20000) begin
      u_if.out_valid_i = 1'($urandom_range(0, 1));
      u_if.in_ready_i  = 1'($urandom_range(0, 1));
      u_if.out_data_i  = byte_t'($urandom);
      acc = int'(u_if.out_valid_i & u_if.out_ready_o);
      tick();
      budget++;
      if (acc != 0) wcnt++;
    end
    if (wcnt < 1000) chk("random_timeout", wcnt, 1000);
    u_if.out_valid_i = 1'b0;
    u_if.in_ready_i  = 1'b1;
    repeat (20) tick();
    u_if.in_ready_i = 1'b0;
    chk("random_drained", int'(level_o), 0);
    repeat (12) tick();

    // RX LED: single accept, then two accepts 5 cycles apart.
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      u_if.out_valid_i = (k == 0);
      u_if.out_data_i  = 8'h10;
      tick();
      if (k == 0) chk("rx_rise", int'(rx_led_o), 1);
      hi += int'(rx_led_o);
    end
    chk("rx_single_len", hi, 8);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      u_if.out_valid_i = (k == 0 || k == 5);
      u_if.out_data_i  = byte_t'(8'h20 + k);
      tick();
      hi += int'(rx_led_o);
    end
    chk("rx_retrig_len", hi, 13);

    // TX LED: same pattern on reads of the three queued bytes.
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      u_if.in_ready_i = (k == 0);
      tick();
      if (k == 0) chk("tx_rise", int'(tx_led_o), 1);
      hi += int'(tx_led_o);
    end
    chk("tx_single_len", hi, 8);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      u_if.in_ready_i = (k == 0 || k == 5);
      tick();
      hi += int'(tx_led_o);
    end
    chk("tx_retrig_len", hi, 13);
    chk("led_final_level", int'(level_o), 0);
    u_if.in_ready_i = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
